// File: rtl/mips_pkg.sv
// Shared MIPS load/store opcodes, FSM state type and access-size decode
// for the data-memory access unit.
package mips_pkg;

    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    typedef struct packed {
        logic  valid;
        logic  is_store;
        size_t size;
        logic  sign_ext;
    } op_dec_t;

    function automatic op_dec_t decode_op(input logic [5:0] op);
        op_dec_t d;
        d = '{valid: 1'b0, is_store: 1'b0, size: SZ_W, sign_ext: 1'b0};
        case (op)
            LB:  d = '{valid: 1'b1, is_store: 1'b0, size: SZ_B, sign_ext: 1'b1};
            LH:  d = '{valid: 1'b1, is_store: 1'b0, size: SZ_H, sign_ext: 1'b1};
            LW:  d = '{valid: 1'b1, is_store: 1'b0, size: SZ_W, sign_ext: 1'b0};
            LBU: d = '{valid: 1'b1, is_store: 1'b0, size: SZ_B, sign_ext: 1'b0};
            LHU: d = '{valid: 1'b1, is_store: 1'b0, size: SZ_H, sign_ext: 1'b0};
            SB:  d = '{valid: 1'b1, is_store: 1'b1, size: SZ_B, sign_ext: 1'b0};
            SH:  d = '{valid: 1'b1, is_store: 1'b1, size: SZ_H, sign_ext: 1'b0};
            SW:  d = '{valid: 1'b1, is_store: 1'b1, size: SZ_W, sign_ext: 1'b0};
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte/halfword lane logic: load extract/extend and
// store merge into a full memory word.
module dmem_lane_align
    import mips_pkg::*;
#(
    parameter int BIG_ENDIAN = 1
) (
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  size_t       size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [1:0]  lane;
    logic [4:0]  shift;
    logic [31:0] shifted;
    logic [31:0] mask;

    always_comb begin
        lane      = '0;
        mask      = '1;
        load_data = word;
        // Lane index counts bytes up from bit 0; big-endian mirrors the offset.
        case (size)
            SZ_B: begin
                lane = (BIG_ENDIAN != 0) ? ~offset : offset;
                mask = 32'h0000_00FF;
            end
            SZ_H: begin
                lane = (BIG_ENDIAN != 0) ? {~offset[1], 1'b0} : {offset[1], 1'b0};
                mask = 32'h0000_FFFF;
            end
            default: ;
        endcase
        shift   = {lane, 3'b000};
        shifted = word >> shift;
        case (size)
            SZ_B:    load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            SZ_H:    load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: load_data = word;
        endcase
        merged = (word & ~(mask << shift)) | ((wdata & mask) << shift);
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store initiator for a word-only data memory port.
// Optional access trace: define DMEM_ACCESS_TRACE_EN.
module dmem_access_unit
    import mips_pkg::*;
#(
    parameter int         BIG_ENDIAN = 1,
    parameter logic [5:0] NOP_OP     = 6'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_fault,
    output logic [31:0] resp_rdata,
    output logic [5:0]  mem_op,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writevalue,
    input  logic [31:0] mem_readvalue
);

    state_t      state, state_n;
    logic [5:0]  op_q;
    logic [31:0] addr_q, wdata_q, merged_q;
    op_dec_t     req_dec, cur_dec;
    logic        misaligned;
    logic [31:0] load_data, merged;

    assign req_dec   = decode_op(req_op);
    assign cur_dec   = decode_op(op_q);
    assign req_ready = (state == IDLE);
    assign misaligned = ((cur_dec.size == SZ_H) && addr_q[0]) ||
                        ((cur_dec.size == SZ_W) && (addr_q[1:0] != 2'b00));

    dmem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
        .word      (mem_readvalue),
        .offset    (addr_q[1:0]),
        .size      (cur_dec.size),
        .sign_ext  (cur_dec.sign_ext),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            merged_q   <= '0;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= state_n;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (req_valid && req_dec.valid) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                    end
                end
                ACCESS: begin
                    if (misaligned) begin
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b1;
                    end else if (!cur_dec.is_store) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                    end else if (cur_dec.size == SZ_W) begin
                        resp_valid <= 1'b1;
                    end else begin
                        merged_q <= merged;
                    end
                end
                WRITE: resp_valid <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n        = state;
        mem_op         = NOP_OP;
        mem_address    = '0;
        mem_writevalue = '0;
        case (state)
            IDLE: begin
                if (req_valid && req_dec.valid)
                    state_n = ACCESS;
            end
            ACCESS: begin
                mem_address = {addr_q[31:2], 2'b00};
                state_n     = IDLE;
                if (!misaligned) begin
                    if (!cur_dec.is_store) begin
                        mem_op = LW;
                    end else if (cur_dec.size == SZ_W) begin
                        mem_op         = SW;
                        mem_writevalue = wdata_q;
                    end else begin
                        state_n = WRITE;
                    end
                end
            end
            WRITE: begin
                mem_address    = {addr_q[31:2], 2'b00};
                mem_op         = SW;
                mem_writevalue = merged_q;
                state_n        = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef DMEM_ACCESS_TRACE_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (mem_op == LW)
                $display("dmem: word %0h LW read %08h", mem_address >> 2, mem_readvalue);
            else if (mem_op == SW)
                $display("dmem: word %0h SW write %08h", mem_address >> 2, mem_writevalue);
            if (state == ACCESS && misaligned)
                $display("dmem: misaligned access at %08h", addr_q);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit with a behavioural word memory
// and a response scoreboard.
module tb_dmem_access_unit;
    import mips_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_fault;
    logic [31:0] resp_rdata;
    logic [5:0]  mem_op;
    logic [31:0] mem_address;
    logic [31:0] mem_writevalue;
    logic [31:0] mem_readvalue;

    logic [31:0] mem [0:63];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sw_count = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          acc_cyc;
    } exp_t;
    exp_t sbq[$];
    int   resp_cycs[$];

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    dmem_access_unit #(.BIG_ENDIAN(1), .NOP_OP(6'h00)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_fault     (resp_fault),
        .resp_rdata     (resp_rdata),
        .mem_op         (mem_op),
        .mem_address    (mem_address),
        .mem_writevalue (mem_writevalue),
        .mem_readvalue  (mem_readvalue)
    );

    always #5 clock = ~clock;

    assign mem_readvalue = mem[mem_address[7:2]];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_op == SW)
            mem[mem_address[7:2]] <= mem_writevalue;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mem_op == SW)
            sw_count++;
        if (resp_valid) begin
            resp_cycs.push_back(cyc);
            if (sbq.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_fault", {31'b0, resp_fault}, {31'b0, e.fault});
                chk("resp_latency", cyc - e.acc_cyc, e.lat);
                chk("ready_in_resp", {31'b0, req_ready}, 32'd1);
            end
        end
    end

    task automatic send(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] er, input logic ef, input int el, input bit push);
        int n;
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        if (push)
            sbq.push_back('{er, ef, el, cyc});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("drain_pending", sbq.size(), 32'd0);
        @(negedge clock);
    endtask

    task automatic run_vec(input int i);
        send(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].fault, vecs[i].lat, 1'b1);
    endtask

    initial begin
        int sw0;
        int nresp;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h1122_3344;
        mem[1] = 32'hCAFE_F00D;
        mem[4] = 32'h8081_7F02;
        mem[8] = 32'hDEAD_BEEF;

        // Loads on the original word, then everything after the SB at 0x12.
        vecs.push_back('{LB,  32'h11, 32'h0,         32'hFFFF_FF81, 1'b0, 1});
        vecs.push_back('{LBU, 32'h11, 32'h0,         32'h0000_0081, 1'b0, 1});
        vecs.push_back('{LH,  32'h12, 32'h0,         32'h0000_7F02, 1'b0, 1});
        vecs.push_back('{LW,  32'h10, 32'h0,         32'h8081_AB02, 1'b0, 1});
        vecs.push_back('{LHU, 32'h10, 32'h0,         32'h0000_8081, 1'b0, 1});
        vecs.push_back('{LH,  32'h10, 32'h0,         32'hFFFF_8081, 1'b0, 1});
        vecs.push_back('{LB,  32'h13, 32'h0,         32'h0000_0002, 1'b0, 1});
        vecs.push_back('{LB,  32'h12, 32'h0,         32'hFFFF_FFAB, 1'b0, 1});
        vecs.push_back('{SH,  32'h13, 32'hFFFF_FFFF, 32'h0,         1'b1, 1});
        vecs.push_back('{LW,  32'h12, 32'h0,         32'h0,         1'b1, 1});
        vecs.push_back('{LH,  32'h11, 32'h0,         32'h0,         1'b1, 1});
        vecs.push_back('{SW,  32'h15, 32'hFFFF_FFFF, 32'h0,         1'b1, 1});
        vecs.push_back('{SH,  32'h10, 32'h1234_5678, 32'h0,         1'b0, 2});
        vecs.push_back('{LW,  32'h10, 32'h0,         32'h5678_AB02, 1'b0, 1});
        vecs.push_back('{SW,  32'h14, 32'h0BAD_F00D, 32'h0,         1'b0, 1});
        vecs.push_back('{LW,  32'h14, 32'h0,         32'h0BAD_F00D, 1'b0, 1});
        vecs.push_back('{LBU, 32'h17, 32'h0,         32'h0000_000D, 1'b0, 1});
        vecs.push_back('{LB,  32'h14, 32'h0,         32'h0000_000B, 1'b0, 1});
        vecs.push_back('{SB,  32'h17, 32'h0000_12FF, 32'h0,         1'b0, 2});
        vecs.push_back('{LW,  32'h14, 32'h0,         32'h0BAD_F0FF, 1'b0, 1});
        vecs.push_back('{LHU, 32'h16, 32'h0,         32'h0000_F0FF, 1'b0, 1});
        vecs.push_back('{LH,  32'h16, 32'h0,         32'hFFFF_F0FF, 1'b0, 1});

        reset = 1'b1;
        req_valid = 1'b0;
        req_op = 6'h00;
        req_addr = '0;
        req_wdata = '0;
        #3;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_op", {26'b0, mem_op}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_writevalue", mem_writevalue, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) run_vec(i);
        drain();

        // SB: read cycle issues no memory op, write cycle issues SW of the merged word.
        send(SB, 32'h12, 32'h0000_00AB, 32'h0, 1'b0, 2, 1'b1);
        @(negedge clock);
        chk("sb_access_mem_op", {26'b0, mem_op}, 32'h00);
        @(negedge clock);
        chk("sb_write_mem_op", {26'b0, mem_op}, {26'b0, SW});
        chk("sb_write_address", mem_address, 32'h10);
        chk("sb_write_value", mem_writevalue, 32'h8081_AB02);
        drain();

        for (int i = 3; i < 12; i++) begin
            if (i == 8) sw0 = sw_count;
            run_vec(i);
            if (i == 11) begin
                drain();
                chk("fault_no_sw", sw_count - sw0, 32'd0);
                chk("fault_word_kept", mem[4], 32'h8081_AB02);
            end
        end
        for (int i = 12; i < vecs.size(); i++) run_vec(i);
        drain();

        // Back-to-back: second request accepted in the first response cycle.
        resp_cycs.delete();
        send(LW, 32'h0, 32'h0, 32'h1122_3344, 1'b0, 1, 1'b1);
        send(LW, 32'h4, 32'h0, 32'hCAFE_F00D, 1'b0, 1, 1'b1);
        send(LW, 32'h0, 32'h0, 32'h1122_3344, 1'b0, 1, 1'b1);
        drain();
        chk("b2b_count", resp_cycs.size(), 32'd3);
        if (resp_cycs.size() == 3) begin
            chk("b2b_spacing1", resp_cycs[1] - resp_cycs[0], 32'd2);
            chk("b2b_spacing2", resp_cycs[2] - resp_cycs[1], 32'd2);
        end

        // Reset during the ACCESS cycle of an SH: aborted, never written.
        sw0 = sw_count;
        send(SH, 32'h20, 32'h0000_5555, 32'h0, 1'b0, 2, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("arst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("arst_mem_op", {26'b0, mem_op}, 32'd0);
        chk("arst_mem_address", mem_address, 32'd0);
        chk("arst_mem_writevalue", mem_writevalue, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("arst_no_sw", sw_count - sw0, 32'd0);
        chk("arst_word_kept", mem[8], 32'hDEAD_BEEF);

        // Non load/store opcode is ignored.
        nresp = resp_cycs.size();
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = 6'h00;
        req_addr  = 32'h10;
        repeat (3) begin
            @(negedge clock);
            chk("ign_req_ready", {31'b0, req_ready}, 32'd1);
            chk("ign_mem_op", {26'b0, mem_op}, 32'd0);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("ign_no_resp", resp_cycs.size() - nresp, 32'd0);
        send(LW, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 1, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- CPU-side initiator for the word-only data memory port (op/address/writevalue/readvalue).
- Accepts load/store requests from the MEM stage via a valid/ready handshake.
- Performs byte and halfword accesses on the word memory: lane extraction and sign/zero extension for loads, read-modify-write for sub-word stores.
- Flags misaligned accesses as faults.

Parameters:
- BIG_ENDIAN, 1: 1 = byte offset 0 is bits [31:24]; 0 = byte offset 0 is bits [7:0].
- NOP_OP, 6'h00: value driven on mem_op when no memory read/write is issued.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept (high only in IDLE)
- req_op  in  6  MIPS opcode: LB, LH, LW, LBU, LHU, SB, SH, SW
- req_addr  in  32  byte address (base+offset already summed)
- req_wdata  in  32  store data (rt); low byte/half used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_fault  out  1  qualifies resp_valid: misaligned access, no memory write
- resp_rdata  out  32  extended load result; 0 for stores and faults
- mem_op  out  6  LW, SW or NOP_OP to data memory
- mem_address  out  32  word-aligned byte address {addr[31:2],2'b00}
- mem_writevalue  out  32  full word to write
- mem_readvalue  in  32  combinational read data from memory

Behaviour:
- Reset (async): state=IDLE, req_ready=1, resp_valid=0, resp_fault=0, resp_rdata=0, mem_op=NOP_OP, mem_address=0, mem_writevalue=0.
- Memory model: read is combinational within the cycle; write commits at the rising edge while mem_op=SW.
- States: IDLE, ACCESS, WRITE.
- IDLE: handshake fires when req_valid && req_ready. Op, addr and wdata are registered, then state goes to ACCESS.
  - Opcodes outside the eight load/store ops are ignored: no state change, no response.
- Alignment: halfword ops need addr[0]=0; word ops need addr[1:0]=0; byte ops are always aligned.
- ACCESS, misaligned: mem_op=NOP_OP. At the next edge: resp_valid=1, resp_fault=1, resp_rdata=0, return to IDLE.
- ACCESS, load: mem_op=LW. At the next edge, the selected lane of mem_readvalue is extracted and extended into resp_rdata (LB/LH sign-extend, LBU/LHU zero-extend, LW passthrough). Then resp_valid=1 and return to IDLE.
- ACCESS, SW: mem_op=SW, mem_writevalue=wdata. At the next edge: resp_valid=1, return to IDLE.
- ACCESS, SB/SH: mem_op=NOP_OP. mem_readvalue is captured at the edge, the store lane is merged in, and state goes to WRITE.
- WRITE: mem_op=SW, mem_writevalue=merged word. At the next edge: resp_valid=1, return to IDLE.
- Latency from accept edge to resp_valid:
  - 1 cycle for loads, SW and faults.
  - 2 cycles for SB/SH.
- resp_valid lasts exactly one cycle; there is no backpressure on the response.
- req_ready is high during the resp_valid cycle, so back-to-back requests are allowed.
- mem_address and mem_op hold only during ACCESS/WRITE. In IDLE, mem_op=NOP_OP.
- Reset mid-operation: return to IDLE immediately. An RMW reset before the WRITE edge never writes. No response is emitted for the aborted request.

Optional Feature:
- Macro DMEM_ACCESS_TRACE_EN.
- Defined: at each rising edge where mem_op is LW or SW, $display the word index (address>>2), the op, and the read or write value. Each fault also prints its address.
- Undefined: no simulation output; RTL is functionally identical.

Decomposition:
- Package mips_pkg holds:
  - opcode localparams LB=6'h20, LH=6'h21, LW=6'h23, LBU=6'h24, LHU=6'h25, SB=6'h28, SH=6'h29, SW=6'h2B;
  - the state enum typedef;
  - the size/sign decode function.
- Sub-module dmem_lane_align (pure combinational):
  - load-side extract/extend;
  - store-side merge from word, offset, size and BIG_ENDIAN.

Test Plan:
- Word 0x10 = 0x8081_7F02, BIG_ENDIAN=1. LB @0x11 -> resp_rdata 0xFFFF_FF81 one cycle after accept; LBU @0x11 -> 0x0000_0081; LH @0x12 -> 0x0000_7F02.
- SB @0x12, wdata 0x0000_00AB -> mem_op sequence NOP then SW at 0x10, mem_writevalue 0x8081_AB02, resp_valid 2 cycles after accept; a following LW @0x10 returns 0x8081_AB02.
- SH @0x13 -> resp_valid with resp_fault=1, resp_rdata 0, mem_op never SW, word unchanged. LW @0x12 also faults.
- Back-to-back: LW @0x0 accepted during the previous resp_valid cycle -> req_ready never drops in IDLE, responses one per 2 cycles.
- Reset asserted during the ACCESS cycle of SH @0x20 -> no SW issued, no resp_valid, all outputs return to reset values asynchronously.
- req_valid with op 6'h00 (R-type) -> ignored: req_ready stays 1, no resp_valid, mem_op NOP.
